gray_step_ctrl: RTL and testbench
=================================

# gray_step_ctrl

Command-driven sequencer for a Gray-code position counter. A requester issues a move command (direction, step count, step rate) over a valid/ready handshake. The block steps an internal position counter at the programmed rate, publishes the position as registered Gray code (exactly one bit changes per step), and pulses `done_o` when the move completes or is aborted. It sits between a control FSM and any Gray-coded consumer, such as a stepper phase driver or a cross-domain pointer.

## Interface
- `width_p`, default 4: position width; Gray and binary outputs.
- `steps_width_p`, default 8: width of the step-count field.
- `rate_width_p`, default 8: width of the step-interval field.

- `clk_i`  in  1  clock; all state changes on posedge.
- `reset_i`  in  1  asynchronous, active-low reset; clears all state immediately while low.
- `cmd_valid_i`  in  1  command present.
- `cmd_ready_o`  out  1  block can accept a command; high only in IDLE.
- `cmd_dir_i`  in  1  1 = count up, 0 = count down.
- `cmd_steps_i`  in  steps_width_p  number of steps to take (0 is legal).
- `cmd_rate_i`  in  rate_width_p  step interval R; one step every R+1 cycles.
- `abort_i`  in  1  terminate the current move.
- `gray_o`  out  width_p  registered Gray code of the position.
- `pos_o`  out  width_p  registered binary position.
- `busy_o`  out  1  high in RUN.
- `done_o`  out  1  one-cycle completion pulse.
- `aborted_o`  out  1  qualifies `done_o`; 1 = the move ended by abort.

## Operation
- States:
  - IDLE: `cmd_ready_o`=1.
  - RUN: steps are issued.
  - DONE: `done_o`=1 for exactly one cycle, then IDLE.
- Accept: `cmd_valid_i & cmd_ready_o` at a posedge. Latch dir, rate into `div_r`, and steps into `rem_r`.
  - steps ≠ 0 → RUN.
  - steps = 0 → DONE with `aborted_o`=0 and no position change.
- RUN, per cycle:
  - `div_r` ≠ 0: decrement `div_r`.
  - `div_r` = 0: take one step, reload `div_r` with the latched rate, decrement `rem_r`.
  - `rem_r` = 1 at the step → DONE.
- Step arithmetic:
  - Up: `pos` + 1 mod 2^width_p (wraps max → 0).
  - Down: `pos` − 1 mod 2^width_p (wraps 0 → max).
- `gray_o` is computed from the next position and registered in the same edge as `pos_o` (no lag). It equals `pos_o ^ (pos_o >> 1)` at all times, and successive values differ in exactly one bit, including at wrap.
- Abort:
  - `abort_i` high in RUN → DONE next edge with `aborted_o`=1.
  - If a step is due in the same cycle as the abort, abort wins and no step is taken.
  - `abort_i` is ignored in IDLE and DONE.
- Position persists across commands; only reset clears it.
- Commands presented while not ready are held by the requester; the block never drops or queues them.

## Timing
- Reset values: state=IDLE, `pos_o`=0, `gray_o`=0, `cmd_ready_o`=1, `busy_o`=0, `done_o`=0, `aborted_o`=0, `div_r`=0, `rem_r`=0.
- Reset is asserted asynchronously and released synchronously by the integrator. Reset mid-move discards the move; no `done_o` is issued.
- Let the accept edge be T0. With rate R and N steps:
  - Step k updates `pos_o`/`gray_o` at edge T0 + k(R+1).
  - `done_o` is high during the cycle after edge T0 + N(R+1).
  - The next accept is possible at the edge after that, giving one idle bubble minimum.
- steps=0: `done_o` is high in the cycle after T0.
- `cmd_ready_o` and `busy_o` are registered state decodes: `cmd_ready_o` falls and `busy_o` rises after T0.
- R=0 steps every cycle. R=max steps every 2^rate_width_p cycles.

## Test plan
- Reset, then up move N=5, R=0 → `gray_o` sequence 0,1,3,2,6,7 on consecutive edges after accept. `done_o` pulses once with `aborted_o`=0. Final `pos_o`=5.
- From `pos_o`=1, down move N=3, R=2 → steps every 3 cycles; `pos_o` 0, 15, 14; `gray_o` 0, 8, 9. Wrap changes one bit.
- N=0, R=7 → `done_o` one cycle after accept; `pos_o` unchanged; `busy_o` never rises.
- Up move N=10, R=1, `abort_i` asserted on the cycle the 3rd step is due → exactly 2 steps taken; `done_o`=1 and `aborted_o`=1.
- `cmd_valid_i` held high continuously with back-to-back commands → each accepted only in IDLE with one DONE bubble between them. A checker verifies Hamming distance 1 between successive `gray_o` values over a randomized 10k-cycle run.
- `reset_i` driven low mid-move, asynchronously between edges → all outputs return to reset values immediately; no `done_o`; next command starts from `pos_o`=0.

Source files
------------

// File: rtl/gray_step_ctrl_if.sv
// Command and status bundle for gray_step_ctrl.
// The requester drives through the master modport and the sequencer uses the slave modport.
interface gray_step_ctrl_if #(
    parameter int unsigned width_p       = 4,
    parameter int unsigned steps_width_p = 8,
    parameter int unsigned rate_width_p  = 8
);
    logic                     cmd_valid_i;
    logic                     cmd_ready_o;
    logic                     cmd_dir_i;
    logic [steps_width_p-1:0] cmd_steps_i;
    logic [rate_width_p-1:0]  cmd_rate_i;
    logic                     abort_i;
    logic [width_p-1:0]       gray_o;
    logic [width_p-1:0]       pos_o;
    logic                     busy_o;
    logic                     done_o;
    logic                     aborted_o;

    modport master (
        output cmd_valid_i, cmd_dir_i, cmd_steps_i, cmd_rate_i, abort_i,
        input  cmd_ready_o, gray_o, pos_o, busy_o, done_o, aborted_o
    );

    modport slave (
        input  cmd_valid_i, cmd_dir_i, cmd_steps_i, cmd_rate_i, abort_i,
        output cmd_ready_o, gray_o, pos_o, busy_o, done_o, aborted_o
    );
endinterface

// File: rtl/gray_step_ctrl.sv
// Command-driven Gray-code position sequencer. It takes one step every rate+1 cycles
// for the commanded number of steps and then pulses done, with the aborted flag showing why the move ended.
module gray_step_ctrl #(
    parameter int unsigned width_p       = 4,
    parameter int unsigned steps_width_p = 8,
    parameter int unsigned rate_width_p  = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    gray_step_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [width_p-1:0]       POS_ONE  = width_p'(1);
    localparam logic [steps_width_p-1:0] REM_ONE  = steps_width_p'(1);
    localparam logic [rate_width_p-1:0]  DIV_ONE  = rate_width_p'(1);

    state_e                   state_q, state_d;
    logic [width_p-1:0]       pos_q, pos_d;
    logic [width_p-1:0]       gray_q, gray_d;
    logic [rate_width_p-1:0]  div_q, div_d;
    logic [rate_width_p-1:0]  rate_q, rate_d;
    logic [steps_width_p-1:0] rem_q, rem_d;
    logic                     dir_q, dir_d;
    logic                     aborted_q, aborted_d;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            pos_q     <= '0;
            gray_q    <= '0;
            div_q     <= '0;
            rate_q    <= '0;
            rem_q     <= '0;
            dir_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            gray_q    <= gray_d;
            div_q     <= div_d;
            rate_q    <= rate_d;
            rem_q     <= rem_d;
            dir_q     <= dir_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        div_d     = div_q;
        rate_d    = rate_q;
        rem_d     = rem_q;
        dir_d     = dir_q;
        aborted_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    dir_d  = bus.cmd_dir_i;
                    rate_d = bus.cmd_rate_i;
                    div_d  = bus.cmd_rate_i;
                    rem_d  = bus.cmd_steps_i;
                    state_d = (bus.cmd_steps_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // An abort takes priority over a step that is due in the same cycle.
                if (bus.abort_i) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else if (div_q != '0) begin
                    div_d = div_q - DIV_ONE;
                end else begin
                    pos_d = dir_q ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
                    div_d = rate_q;
                    rem_d = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The Gray code comes from the next position, so gray_o and pos_o change on the same edge.
        gray_d = pos_d ^ (pos_d >> 1);
    end

    assign bus.cmd_ready_o = (state_q == IDLE);
    assign bus.busy_o      = (state_q == RUN);
    assign bus.done_o      = (state_q == DONE);
    assign bus.aborted_o   = aborted_q;
    assign bus.pos_o       = pos_q;
    assign bus.gray_o      = gray_q;
endmodule

// File: tb/tb_gray_step_ctrl.sv
// Directed bench for gray_step_ctrl. It also checks that successive gray_o values
// differ in exactly one bit and that gray_o matches pos_o.
module tb_gray_step_ctrl;
    logic clk_i;
    logic reset_i;

    gray_step_ctrl_if #(.width_p(4), .steps_width_p(8), .rate_width_p(8)) bus ();

    gray_step_ctrl #(.width_p(4), .steps_width_p(8), .rate_width_p(8)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int unsigned checks;
    int unsigned passes;
    logic [3:0]  prev_gray;
    bit          prev_ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk_i);
        if (reset_i) begin
            chk("gray_eq_pos", {28'd0, bus.gray_o}, {28'd0, bus.pos_o ^ (bus.pos_o >> 1)});
            if (prev_ok && (bus.gray_o !== prev_gray))
                chk("gray_hamming", $countones(bus.gray_o ^ prev_gray), 1);
        end
        prev_gray = bus.gray_o;
        prev_ok   = reset_i;
    endtask

    task automatic issue(input logic dir, input logic [7:0] steps, input logic [7:0] rate);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_dir_i   = dir;
        bus.cmd_steps_i = steps;
        bus.cmd_rate_i  = rate;
        tick();
        bus.cmd_valid_i = 1'b0;
    endtask

    logic [3:0] exp1_gray [5] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7};
    logic [3:0] exp2_pos  [9] = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd15, 4'd15, 4'd15, 4'd14};
    logic [3:0] exp2_gray [9] = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd8, 4'd8, 4'd8, 4'd9};

    initial begin
        int unsigned acc_cnt;
        int unsigned done_cnt;
        logic        was_ready;

        checks  = 0;
        passes  = 0;
        prev_ok = 1'b0;
        prev_gray = '0;
        reset_i = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_dir_i   = 1'b0;
        bus.cmd_steps_i = '0;
        bus.cmd_rate_i  = '0;
        bus.abort_i     = 1'b0;

        // Reset values
        #12;
        chk("rst_pos",     bus.pos_o,       0);
        chk("rst_gray",    bus.gray_o,      0);
        chk("rst_ready",   bus.cmd_ready_o, 1);
        chk("rst_busy",    bus.busy_o,      0);
        chk("rst_done",    bus.done_o,      0);
        chk("rst_aborted", bus.aborted_o,   0);
        tick();
        reset_i = 1'b1;
        tick();

        // Up move N=5 R=0
        issue(1'b1, 8'd5, 8'd0);
        chk("t1_gray0", bus.gray_o, 0);
        chk("t1_busy",  bus.busy_o, 1);
        chk("t1_ready", bus.cmd_ready_o, 0);
        chk("t1_done0", bus.done_o, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t1_gray", bus.gray_o, exp1_gray[k]);
            chk("t1_done", bus.done_o, (k == 4) ? 1 : 0);
        end
        chk("t1_pos",     bus.pos_o, 5);
        chk("t1_aborted", bus.aborted_o, 0);
        chk("t1_busy_end", bus.busy_o, 0);
        tick();
        chk("t1_done_off", bus.done_o, 0);
        chk("t1_ready_back", bus.cmd_ready_o, 1);

        // Bring position to 1, then down N=3 R=2 across the wrap
        issue(1'b0, 8'd4, 8'd0);
        repeat (4) tick();
        chk("t2_pre_done", bus.done_o, 1);
        tick();
        chk("t2_pre_pos", bus.pos_o, 1);
        issue(1'b0, 8'd3, 8'd2);
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("t2_pos",  bus.pos_o,  exp2_pos[k]);
            chk("t2_gray", bus.gray_o, exp2_gray[k]);
            chk("t2_done", bus.done_o, (k == 8) ? 1 : 0);
        end
        tick();
        chk("t2_ready_back", bus.cmd_ready_o, 1);

        // Zero-step command
        issue(1'b0, 8'd0, 8'd7);
        chk("t3_done",    bus.done_o, 1);
        chk("t3_busy",    bus.busy_o, 0);
        chk("t3_pos",     bus.pos_o, 14);
        chk("t3_aborted", bus.aborted_o, 0);
        chk("t3_ready",   bus.cmd_ready_o, 0);
        tick();
        chk("t3_done_off", bus.done_o, 0);
        chk("t3_busy_off", bus.busy_o, 0);
        chk("t3_ready_back", bus.cmd_ready_o, 1);

        // Abort has no effect in IDLE
        bus.abort_i = 1'b1;
        tick();
        tick();
        chk("idle_abort_done", bus.done_o, 0);
        chk("idle_abort_pos",  bus.pos_o, 14);
        bus.abort_i = 1'b0;

        // Up N=10 R=1, abort when the third step is due
        issue(1'b1, 8'd10, 8'd1);
        tick();
        chk("t4_pos1", bus.pos_o, 14);
        tick();
        chk("t4_pos2", bus.pos_o, 15);
        tick();
        tick();
        chk("t4_pos4", bus.pos_o, 0);
        tick();
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        chk("t4_done",    bus.done_o, 1);
        chk("t4_aborted", bus.aborted_o, 1);
        chk("t4_pos",     bus.pos_o, 0);
        chk("t4_gray",    bus.gray_o, 0);
        chk("t4_busy",    bus.busy_o, 0);
        tick();
        chk("t4_done_off",    bus.done_o, 0);
        chk("t4_aborted_off", bus.aborted_o, 0);
        chk("t4_ready_back",  bus.cmd_ready_o, 1);

        // Back-to-back commands with valid held high
        acc_cnt  = 0;
        done_cnt = 0;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_dir_i   = 1'b1;
        bus.cmd_steps_i = 8'd2;
        bus.cmd_rate_i  = 8'd0;
        for (int i = 0; i < 12; i++) begin
            if (bus.cmd_ready_o) acc_cnt++;
            tick();
            if (bus.done_o) done_cnt++;
        end
        bus.cmd_valid_i = 1'b0;
        chk("t5_accepts", acc_cnt, 3);
        chk("t5_dones",   done_cnt, 3);
        chk("t5_pos",     bus.pos_o, 6);
        chk("t5_ready",   bus.cmd_ready_o, 1);

        // Random traffic with the one-bit-change check running every cycle
        for (int i = 0; i < 10000; i++) begin
            if (!bus.cmd_valid_i && ($urandom_range(0, 3) == 0)) begin
                bus.cmd_valid_i = 1'b1;
                bus.cmd_dir_i   = 1'($urandom_range(0, 1));
                bus.cmd_steps_i = 8'($urandom_range(0, 9));
                bus.cmd_rate_i  = 8'($urandom_range(0, 3));
            end
            bus.abort_i = ($urandom_range(0, 31) == 0);
            was_ready = bus.cmd_ready_o;
            tick();
            if (bus.cmd_valid_i && was_ready) bus.cmd_valid_i = 1'b0;
        end
        bus.cmd_valid_i = 1'b0;
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        tick();
        tick();
        chk("t5r_idle", bus.cmd_ready_o, 1);

        // Asynchronous reset in the middle of a move
        issue(1'b1, 8'd8, 8'd3);
        tick();
        tick();
        #2;
        reset_i = 1'b0;
        #1;
        chk("t6_pos",     bus.pos_o, 0);
        chk("t6_gray",    bus.gray_o, 0);
        chk("t6_ready",   bus.cmd_ready_o, 1);
        chk("t6_busy",    bus.busy_o, 0);
        chk("t6_done",    bus.done_o, 0);
        chk("t6_aborted", bus.aborted_o, 0);
        tick();
        reset_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_done", bus.done_o, 0);
            chk("t6_pos_held", bus.pos_o, 0);
        end
        issue(1'b1, 8'd1, 8'd0);
        tick();
        chk("t6_next_done", bus.done_o, 1);
        chk("t6_next_pos",  bus.pos_o, 1);
        chk("t6_next_gray", bus.gray_o, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
